// File: rtl/score_led_ctrl_if.sv
// Signal bundle between the game input logic (master) and the score/LED
// sequencer (slave). Outputs of the sequencer come back to the master side.
interface score_led_ctrl_if;
  // start, hit and miss are single-cycle event pulses sampled on the rising
  // clock edge. There is no backpressure: a pulse the sequencer does not
  // accept in its current mode is dropped, never held or retried.
  logic       start;
  logic       hit;
  logic       miss;
  logic [1:0] leds_ctrl;
  logic [6:0] score;
  logic       game_over;
  logic [2:0] state_dbg;

  modport master (
    output start,
    output hit,
    output miss,
    input  leds_ctrl,
    input  score,
    input  game_over,
    input  state_dbg
  );

  modport slave (
    input  start,
    input  hit,
    input  miss,
    output leds_ctrl,
    output score,
    output game_over,
    output state_dbg
  );
endinterface

// File: rtl/score_led_ctrl.sv
// Game sequencer for the LED display mux: tracks score and misses and steps
// the display through reset-code, live-score, win-blink and game-over modes.
module score_led_ctrl #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned BLINK_CYCLES = 2,
  parameter int unsigned WIN_SCORE    = 100,
  parameter int unsigned MAX_MISSES   = 3
) (
  input logic            clk,
  input logic            reset,
  score_led_ctrl_if.slave bus
);

  localparam int unsigned TMAX = (RESET_CYCLES > BLINK_CYCLES) ? RESET_CYCLES : BLINK_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned MW   = $clog2(MAX_MISSES + 1);

  localparam logic [TW-1:0] T_RESET = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] T_BLINK = TW'(BLINK_CYCLES - 1);
  localparam logic [6:0]    WIN_S   = 7'(WIN_SCORE);
  localparam logic [MW-1:0] MAX_M   = MW'(MAX_MISSES);

  localparam logic [1:0] LEDS_OFF   = 2'd0;
  localparam logic [1:0] LEDS_ON    = 2'd1;
  localparam logic [1:0] LEDS_RESET = 2'd2;
  localparam logic [1:0] LEDS_SCORE = 2'd3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHOW_RESET = 3'd1,
    PLAY       = 3'd2,
    WIN        = 3'd3,
    LOSE       = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    score_q, score_d;
  logic [MW-1:0] miss_q,  miss_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          blink_q, blink_d;
  logic [1:0]    leds_q,  leds_d;
  logic          over_q,  over_d;
  logic          go;

  // A start pulse is honoured everywhere except while the reset code is
  // already being shown; illegal encodings only recover to IDLE.
  assign go = bus.start && (state_q inside {IDLE, PLAY, WIN, LOSE});

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    miss_d  = miss_q;
    timer_d = timer_q;
    blink_d = blink_q;

    if (go) begin
      state_d = SHOW_RESET;
      score_d = '0;
      miss_d  = '0;
      timer_d = T_RESET;
      blink_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        SHOW_RESET: begin
          if (timer_q == '0) begin
            state_d = PLAY;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        PLAY: begin
          // A hit wins over a simultaneous miss; the miss is discarded.
          if (bus.hit) begin
            score_d = score_q + 7'd1;
            if ((score_q + 7'd1) == WIN_S) begin
              state_d = WIN;
              timer_d = T_BLINK;
              blink_d = 1'b0;
            end
          end else if (bus.miss) begin
            miss_d = miss_q + MW'(1);
            if ((miss_q + MW'(1)) == MAX_M) begin
              state_d = LOSE;
            end
          end
        end
        WIN: begin
          // blink_q = 0 is the lit half of the blink period.
          if (timer_q == '0) begin
            blink_d = ~blink_q;
            timer_d = T_BLINK;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        LOSE: ;
        default: begin
          state_d = IDLE;
          score_d = '0;
          miss_d  = '0;
          timer_d = '0;
          blink_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    leds_d = LEDS_OFF;
    over_d = 1'b0;
    case (state_d)
      SHOW_RESET: leds_d = LEDS_RESET;
      PLAY:       leds_d = LEDS_SCORE;
      WIN: begin
        leds_d = blink_d ? LEDS_OFF : LEDS_ON;
        over_d = 1'b1;
      end
      LOSE: begin
        leds_d = LEDS_SCORE;
        over_d = 1'b1;
      end
      default:    leds_d = LEDS_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      miss_q  <= '0;
      timer_q <= '0;
      blink_q <= 1'b0;
      leds_q  <= LEDS_OFF;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      leds_q  <= leds_d;
      over_q  <= over_d;
    end
  end

  assign bus.leds_ctrl = leds_q;
  assign bus.score     = score_q;
  assign bus.game_over = over_q;
  assign bus.state_dbg = state_q;

endmodule
